// File: rtl/rr_arbiter_8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter and the decoder users
// that consume its one-hot grant.
package rr_arbiter_8_pkg;
    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_e;

    function automatic logic [NUM_REQ-1:0] onehot3(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] one;
        one = {{(NUM_REQ-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction
endpackage

// File: rtl/rr_arbiter_8_pick.sv
// Combinational round-robin pick: first set request at or above ptr,
// wrapping 7->0, found with a double-width masked priority scan.
module rr_pick_8
    import rr_arbiter_8_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);
    logic [NUM_REQ-1:0]   upper_mask;
    logic [2*NUM_REQ-1:0] scan;

    // Low half keeps bits at/above ptr; the unmasked high half supplies the wrap.
    assign upper_mask = {NUM_REQ{1'b1}} << ptr;
    assign scan       = {req, req & upper_mask};

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = 2*NUM_REQ-1; i >= 0; i--) begin
            if (scan[i]) begin
                found = 1'b1;
                idx   = i[IDX_W-1:0];
            end
        end
    end
endmodule

// File: rtl/rr_arbiter_8.sv
// 8-requester round-robin arbiter with registered one-hot grant, owner
// release/withdrawal handling and an optional per-owner hold limit.
module rr_arbiter_8
    import rr_arbiter_8_pkg::*;
#(
    parameter int HOLD_MAX = 16,
    parameter int HOLD_W   = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               release_i,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid
);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = {HOLD_W{1'b1}};

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic               gnt_valid_q, gnt_valid_d;

    logic [IDX_W-1:0]   pick_ptr;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic               hold_hit;
    logic               rel_event;

    // While owned, scan from just past the owner so it gets lowest priority.
    assign pick_ptr  = (state_q == OWNED) ? gnt_idx_q + 3'd1 : ptr_q;
    assign hold_hit  = (HOLD_MAX != 0) && (hold_cnt_q == HOLD_LAST);
    assign rel_event = release_i || !req[gnt_idx_q] || hold_hit;

    rr_pick_8 u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d     = OWNED;
                    gnt_d       = onehot3(pick_idx);
                    gnt_idx_d   = pick_idx;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = '0;
                end
            end
            OWNED: begin
                if (rel_event) begin
                    ptr_d = gnt_idx_q + 3'd1;
                    if (pick_found) begin
                        gnt_d      = onehot3(pick_idx);
                        gnt_idx_d  = pick_idx;
                        hold_cnt_d = '0;
                    end else begin
                        state_d     = IDLE;
                        gnt_d       = '0;
                        gnt_idx_d   = '0;
                        gnt_valid_d = 1'b0;
                    end
                end else if (hold_cnt_q != HOLD_SAT) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Round-robin arbiter that shares one downstream resource among 8 requesters. It issues a registered one-hot grant plus its 3-bit binary index, and holds the grant until the owner releases it or a hold limit expires. It sits between the requester ports and the 3-to-8 select/enable datapath, so that datapath is driven by exactly one owner at a time. Fairness comes from a rotating priority pointer.

## Interface
- HOLD_MAX, default 16: maximum consecutive grant cycles per owner; 0 disables the limit.
- HOLD_W, default 5: counter width; must satisfy HOLD_MAX < 2**HOLD_W.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  8  request vector; bit i is requester i.
- release  in  1  owner done; qualified only while gnt_valid=1.
- gnt  out  8  registered one-hot grant; all zeros when idle.
- gnt_idx  out  3  binary index of the owner; equals log2(gnt) while gnt_valid=1.
- gnt_valid  out  1  a grant is active.

## Operation
- State machine with two states, IDLE and OWNED.
- IDLE:
  - If req != 0, select the first set bit scanning upward from ptr, wrapping 7->0.
  - Register gnt/gnt_idx, set gnt_valid, clear hold_cnt, go to OWNED.
  - If req == 0, stay in IDLE with outputs zero.
- OWNED: a release event occurs when any of the following holds:
  - release=1, or
  - req[gnt_idx]=0 (requester withdrew), or
  - HOLD_MAX != 0 and hold_cnt == HOLD_MAX-1.
- On a release event:
  - ptr <= gnt_idx+1, wrapping mod 8.
  - Re-arbitrate in the same cycle using the new pointer, i.e. scan from gnt_idx+1.
  - The previous owner has the lowest priority. It is re-granted only if no other bit is set and it still requests.
  - If a winner exists, gnt switches directly to it, hold_cnt is cleared, and the state stays OWNED. There is no bubble cycle.
  - If no winner, outputs go to zero and the state returns to IDLE.
- No release event: grant held unchanged; hold_cnt increments, saturating at 2**HOLD_W-1.
- release while gnt_valid=0 is ignored.
- Requests appearing or disappearing on non-owner bits never disturb an active grant.
- Invariants:
  - gnt is one-hot or zero.
  - gnt == (1 << gnt_idx) whenever gnt_valid=1.
  - gnt_idx = 0 whenever gnt_valid=0.

## Timing
- Reset: gnt=8'h00, gnt_idx=0, gnt_valid=0, ptr=0, hold_cnt=0, state IDLE.
- Reset asserted mid-grant: outputs drop to zero at that edge, and the pointer returns to 0.
- Grant latency: req sampled at edge N; gnt is visible after edge N, i.e. 1 cycle.
- Release latency: release or withdrawal sampled at edge N; the new grant or zero is visible after edge N.
- Hold limit: with HOLD_MAX=H and the owner continuously requesting, the grant lasts exactly H cycles.
- Release, withdrawal and hold expiry in the same cycle count as one release event; the pointer advances once.
- All outputs are direct flop outputs; there is no combinational path from req or release to the outputs.

## Structure
- Shared package holds:
  - NUM_REQ=8 and IDX_W=3.
  - The state enum {IDLE, OWNED}.
  - A function onehot3(idx) returning 8'b1 << idx, reused by the existing decoder users.
- One sub-module, rr_pick_8:
  - Purely combinational.
  - Inputs req[7:0] and ptr[2:0]; outputs found and idx[2:0].
  - Implemented as a double-width (16-bit) masked priority scan.
- The top level contains the FSM, ptr, hold_cnt and output registers.

## Test plan
- Reset then req=8'h00 for 5 cycles -> gnt=00, gnt_valid=0, gnt_idx=0 throughout.
- req=8'h11 held, release pulsed 1 cycle after each grant -> grant sequence 01, 10, 01, 10 with idx 0, 4, 0, 4 and no bubble cycles.
- req=8'hFF held, HOLD_MAX=4, release never asserted -> each bit is granted for exactly 4 cycles in order 0..7, then wraps to 0.
- Owner idx=3 drops req[3] while req=8'h88 -> next cycle gnt=8'h80, idx=7. Afterwards, with req[3] alone asserted, gnt=8'h08.
- Reset asserted while gnt=8'h20 -> outputs zero next cycle. Then req=8'h24 is granted to bit 2 first, because ptr=0.
- Random req/release for 10k cycles -> one-hot invariant holds, no requester is starved beyond 7·HOLD_MAX cycles, and gnt == 1<<gnt_idx whenever gnt_valid=1.
